krp8_dbus_periph: RTL and testbench

- Memory-mapped peripheral that responds to the KRP8 data-bus initiator (DREQ/nDRW/DADDR/DWDATA/DRDATA) in parallel with DATA_MEM.
- Same synchronous-SRAM timing: 1-cycle read latency, writes committed at the request edge.
- Contains a 32-bit compare timer with sticky match/IRQ and a 4-entry TX byte FIFO drained by an external valid/ready consumer.
- System read mux selects DRDATA from this block when RVALID=1.

---
 rtl/krp8_dbus_periph.sv | 153 +++++++++++++++
 tb/tb_krp8_dbus_periph.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/krp8_dbus_periph.sv
// Data-bus peripheral for the KRP8 initiator: a 32-bit compare timer with sticky
// match/IRQ and a small TX byte FIFO drained by a valid/ready consumer.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   dreq, ndrw          bus request, 0=read / 1=write
//   daddr, dwdata       byte address ([29:12] decode, [4:2] register), write data
//   drdata, rvalid      registered read data, asserted the cycle after a read
//   tx_data, tx_valid   FIFO head byte, FIFO not empty
//   tx_ready            consumer takes the head on tx_valid & tx_ready
//   irq                 registered STATUS.MATCH & CTRL.IE
module krp8_dbus_periph #(
  parameter logic [17:0] BASE       = 18'h00001,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dreq,
  input  logic        ndrw,
  input  logic [29:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        rvalid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] REG_CNT    = 3'd0;
  localparam logic [2:0] REG_CMP    = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_TXDATA = 3'd4;
  localparam logic [2:0] REG_FSTAT  = 3'd5;

  // Register state
  logic [31:0]   cnt, cmp;
  logic [2:0]    ctrl;            // [0] EN, [1] AUTORELOAD, [2] IE
  logic          match, ovf;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  // Next-state values
  logic [31:0]   cnt_n, cmp_n, rdata_c;
  logic [2:0]    ctrl_n;
  logic          match_n, ovf_n;
  logic [7:0]    mem_n [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_n, wr_ptr_n;
  logic [CW-1:0] count_n;

  logic       sel, rd_req, wr_req, hit, push, pop, full, empty;
  logic [2:0] idx;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Address bits outside the decode/index fields are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{daddr[11:5], daddr[1:0]};

  // Bus decode, read mux, timer and FIFO next-state
  always_comb begin : next_state
    cnt_n    = cnt;
    cmp_n    = cmp;
    ctrl_n   = ctrl;
    match_n  = match;
    ovf_n    = ovf;
    mem_n    = mem;
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    count_n  = count;
    rdata_c  = '0;

    sel    = dreq && (daddr[29:12] == BASE);
    idx    = daddr[4:2];
    rd_req = sel && !ndrw;
    wr_req = sel && ndrw;

    case (idx)
      REG_CNT:    rdata_c = cnt;
      REG_CMP:    rdata_c = cmp;
      REG_CTRL:   rdata_c = {29'd0, ctrl};
      REG_STATUS: rdata_c = {30'd0, ovf, match};
      REG_TXDATA: rdata_c = 32'(count);
      REG_FSTAT:  rdata_c = {30'd0, full, empty};
      default:    rdata_c = '0;
    endcase

    // Timer: compare uses current CMP, so a CMP write affects the next edge
    hit = ctrl[0] && (cnt == cmp);
    if (ctrl[0]) cnt_n = (hit && ctrl[1]) ? '0 : cnt + 32'd1;
    if (wr_req && idx == REG_CNT)  cnt_n  = dwdata;
    if (wr_req && idx == REG_CMP)  cmp_n  = dwdata;
    if (wr_req && idx == REG_CTRL) ctrl_n = dwdata[2:0];
    if (wr_req && idx == REG_STATUS) begin
      match_n = match & ~dwdata[0];
      ovf_n   = ovf & ~dwdata[1];
    end
    if (hit) match_n = 1'b1;   // hardware set beats a same-cycle W1C

    // FIFO: a pop in the same cycle frees the slot for a push into a full FIFO
    pop  = tx_valid && tx_ready;
    push = wr_req && (idx == REG_TXDATA) && (!full || pop);
    if (wr_req && (idx == REG_TXDATA) && full && !pop) ovf_n = 1'b1;
    if (push) begin
      mem_n[wr_ptr] = dwdata[7:0];
      wr_ptr_n      = wr_ptr + PW'(1);
    end
    if (pop) rd_ptr_n = rd_ptr + PW'(1);
    count_n = count + CW'(push) - CW'(pop);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      cmp      <= '0;
      ctrl     <= '0;
      match    <= 1'b0;
      ovf      <= 1'b0;
      mem      <= '{default: '0};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drdata   <= '0;
      rvalid   <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      cmp      <= cmp_n;
      ctrl     <= ctrl_n;
      match    <= match_n;
      ovf      <= ovf_n;
      mem      <= mem_n;
      rd_ptr   <= rd_ptr_n;
      wr_ptr   <= wr_ptr_n;
      count    <= count_n;
      rvalid   <= rd_req;
      if (rd_req) drdata <= rdata_c;
      // Head byte is registered from the post-update FIFO so it tracks pushes/pops
      tx_data  <= mem_n[rd_ptr_n];
      tx_valid <= (count_n != '0);
      irq      <= match && ctrl[2];
    end
  end

endmodule

// File: tb/tb_krp8_dbus_periph.sv
// Scoreboard bench for krp8_dbus_periph: directed scenarios plus random bus
// traffic checked against a behavioural model of the register map.
module tb_krp8_dbus_periph;

  localparam logic [17:0] BASE  = 18'h00001;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dreq = 1'b0;
  logic        ndrw = 1'b0;
  logic [29:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic        tx_ready = 1'b0;
  logic [31:0] drdata;
  logic        rvalid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        irq;

  krp8_dbus_periph #(.BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .dreq(dreq), .ndrw(ndrw), .daddr(daddr),
    .dwdata(dwdata), .drdata(drdata), .rvalid(rvalid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_cnt = '0, m_cmp = '0;
  logic [2:0]  m_ctrl = '0;
  logic        m_match = 1'b0, m_ovf = 1'b0, m_irq = 1'b0;
  logic [7:0]  m_fifo [$];
  logic [31:0] exp_rd [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] ra(input logic [17:0] base, input int unsigned i);
    return {base, 7'd0, 3'(i), 2'b00};
  endfunction

  function automatic logic [31:0] m_reg(input logic [2:0] i);
    case (i)
      3'd0: return m_cnt;
      3'd1: return m_cmp;
      3'd2: return {29'd0, m_ctrl};
      3'd3: return {30'd0, m_ovf, m_match};
      3'd4: return 32'(m_fifo.size());
      3'd5: return {30'd0, m_fifo.size() == DEPTH, m_fifo.size() == 0};
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: one bus transfer per rising edge, read value taken before the update
  logic       s_sel, s_rd, s_wr, s_pop, s_full, s_hit;
  logic [2:0] s_ix;
  logic [31:0] s_nxt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = '0; m_cmp = '0; m_ctrl = '0;
      m_match = 1'b0; m_ovf = 1'b0; m_irq = 1'b0;
      m_fifo.delete();
      exp_rd.delete();
    end else begin
      s_sel  = dreq && (daddr[29:12] == BASE);
      s_ix   = daddr[4:2];
      s_rd   = s_sel && !ndrw;
      s_wr   = s_sel && ndrw;
      if (s_rd) exp_rd.push_back(m_reg(s_ix));
      s_pop  = (m_fifo.size() != 0) && tx_ready;
      s_full = (m_fifo.size() == DEPTH);
      s_hit  = m_ctrl[0] && (m_cnt == m_cmp);
      m_irq  = m_match && m_ctrl[2];
      s_nxt  = m_cnt;
      if (m_ctrl[0]) s_nxt = (s_hit && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
      if (s_wr && s_ix == 3'd3) begin
        m_match = m_match && !dwdata[0];
        m_ovf   = m_ovf && !dwdata[1];
      end
      if (s_hit) m_match = 1'b1;
      if (s_wr && s_ix == 3'd4 && s_full && !s_pop) m_ovf = 1'b1;
      if (s_pop) void'(m_fifo.pop_front());
      if (s_wr && s_ix == 3'd4 && (!s_full || s_pop)) m_fifo.push_back(dwdata[7:0]);
      if (s_wr && s_ix == 3'd0) s_nxt = dwdata;
      m_cnt = s_nxt;
      if (s_wr && s_ix == 3'd1) m_cmp = dwdata;
      if (s_wr && s_ix == 3'd2) m_ctrl = dwdata[2:0];
    end
  end

  // Monitor: compares DUT outputs against the scoreboard between edges
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rvalid", 32'(rvalid), 32'(exp_rd.size() != 0));
      if (rvalid && exp_rd.size() != 0) chk("drdata", drdata, exp_rd.pop_front());
      else exp_rd.delete();
      chk("tx_valid", 32'(tx_valid), 32'(m_fifo.size() != 0));
      if (tx_valid && m_fifo.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_fifo[0]));
      chk("irq", 32'(irq), 32'(m_irq));
    end
  end

  // One transfer on the next rising edge; returns 2 time units after that edge
  task automatic bus(input logic rq, input logic w, input logic [29:0] a, input logic [31:0] d);
    dreq = rq; ndrw = w; daddr = a; dwdata = d;
    @(posedge clk);
    #2;
    dreq = 1'b0;
  endtask

  task automatic wr(input int unsigned i, input logic [31:0] d);
    bus(1'b1, 1'b1, ra(BASE, i), d);
  endtask

  task automatic rd_chk(input string name, input int unsigned i, input logic [31:0] exp);
    bus(1'b1, 1'b0, ra(BASE, i), 32'd0);
    chk(name, drdata, exp);
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_drdata"}, drdata, 32'd0);
    chk({name, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({name, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({name, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({name, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [4];
    int unsigned i;
    logic [31:0] d;

    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("por");
    rst_n = 1'b1;

    // Async reset mid-cycle with counter loaded, FIFO holding bytes and a read pending
    wr(0, 32'd5);
    wr(4, 32'h5A);
    wr(4, 32'h6B);
    bus(1'b1, 1'b0, ra(BASE, 3), 32'd0);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    rst_n = 1'b1;
    rd_chk("rst_cnt", 0, 32'd0);
    rd_chk("rst_fifostat", 5, 32'd1);

    // Compare timer with autoreload and IRQ; W1C in the match cycle loses
    wr(1, 32'd3);
    wr(2, 32'h7);
    rd_chk("cnt0", 0, 32'd0);
    rd_chk("cnt1", 0, 32'd1);
    rd_chk("cnt2", 0, 32'd2);
    wr(3, 32'd1);                  // counter equals CMP at this edge
    rd_chk("cnt_reload", 0, 32'd0);
    chk("irq_set", 32'(irq), 32'd1);
    rd_chk("match_sticky", 3, 32'd1);
    wr(2, 32'd0);
    wr(3, 32'd3);
    rd_chk("status_clr", 3, 32'd0);
    rd_chk("cnt_hold", 0, 32'd3);

    // Address decode
    rd_chk("cmp_rd", 1, 32'd3);
    bus(1'b1, 1'b0, ra(18'h00002, 1), 32'd0);
    chk("nosel_rvalid", 32'(rvalid), 32'd0);

    // Overflow into a full FIFO then drain in order
    tx_ready = 1'b0;
    seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int k = 0; k < 4; k++) wr(4, 32'(seq[k]));
    wr(4, 32'hE5);
    rd_chk("fifostat_full", 5, 32'd2);
    rd_chk("status_ovf", 3, 32'd2);
    rd_chk("fifo_count4", 4, 32'd4);
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 32'(tx_valid), 32'd1);
      chk("drain_data", 32'(tx_data), 32'(seq[k]));
      idle();
    end
    chk("drain_empty", 32'(tx_valid), 32'd0);
    wr(3, 32'd2);

    // Push while full with a simultaneous pop
    tx_ready = 1'b0;
    for (int k = 1; k <= 4; k++) wr(4, 32'(k * 8'h11));
    tx_ready = 1'b1;
    wr(4, 32'h77);
    tx_ready = 1'b0;
    rd_chk("pushpop_count", 4, 32'd4);
    rd_chk("pushpop_noovf", 3, 32'd0);
    tx_ready = 1'b1;
    seq = '{8'h22, 8'h33, 8'h44, 8'h77};
    for (int k = 0; k < 4; k++) begin
      chk("pp_data", 32'(tx_data), 32'(seq[k]));
      idle();
    end
    chk("pp_empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Match at all-ones then wrap to zero without autoreload
    wr(1, 32'hFFFF_FFFF);
    wr(0, 32'hFFFF_FFFE);
    wr(2, 32'h1);
    idle();
    idle();
    rd_chk("wrap_cnt0", 0, 32'd0);
    rd_chk("wrap_match", 3, 32'd1);
    rd_chk("wrap_cnt2", 0, 32'd2);
    wr(2, 32'd0);
    wr(3, 32'd3);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tx_ready = 1'($urandom_range(0, 1));
      i = $urandom_range(0, 7);
      case (i)
        0, 1: d = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                               : 32'($urandom_range(0, 24));
        2:    d = 32'($urandom_range(0, 7));
        default: d = $urandom;
      endcase
      bus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          ra(($urandom_range(0, 7) == 0) ? 18'h00002 : BASE, i), d);
      if (n == 1500) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    tx_ready = 1'b0;
    repeat (3) idle();
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
